// File: rtl/bytecode_sequencer_pkg.sv
// Shared types and constants for the bytecode fetch/decode/execute sequencer.
package bytecode_sequencer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OPC_W  = 8;
  localparam int unsigned ARGS_W = 16;
  localparam int unsigned CNT_W  = 2;

  // Return opcodes, shared with the opcode header
  localparam logic [OPC_W-1:0] OP_IRETURN = 8'hAC;
  localparam logic [OPC_W-1:0] OP_ARETURN = 8'hB0;
  localparam logic [OPC_W-1:0] OP_RETURN  = 8'hB1;

  localparam logic [CNT_W-1:0] ARGC_NONE    = 2'd0;
  localparam logic [CNT_W-1:0] STKARGS_NONE = 2'd0;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_OPC,
    ST_DECODE,
    ST_ARG,
    ST_POP,
    ST_EXEC,
    ST_WB,
    ST_NEXT,
    ST_HALT,
    ST_FAULT
  } state_t;

  function automatic logic is_return(input logic [OPC_W-1:0] op);
    return (op == OP_IRETURN) || (op == OP_ARETURN) || (op == OP_RETURN);
  endfunction

endpackage

// File: rtl/bytecode_sequencer_branch_target_calc.sv
// Branch target (opcode address + signed 16-bit offset, modulo 2^PC_W) and take decision.
module bytecode_sequencer_branch_target_calc
  import bytecode_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = 16
) (
  input  logic [PC_W-1:0]   opc_pc,
  input  logic [ARGS_W-1:0] offset,
  input  logic              isgoto,
  input  logic              iscmp,
  input  logic              cmp_true,
  output logic [PC_W-1:0]   target_c,
  output logic              take_c
);

  logic [PC_W-1:0] offset_ext;

  assign offset_ext = PC_W'($signed(offset));
  assign target_c   = opc_pc + offset_ext;
  assign take_c     = isgoto | (iscmp & cmp_true);

endmodule

// File: rtl/bytecode_sequencer.sv
// Multi-cycle fetch/decode/execute controller: owns the PC, fetches opcode and
// argument bytes, sequences stack pops, one execute handshake and the writeback push.
module bytecode_sequencer
  import bytecode_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   pmem_addr,
  output logic              pmem_rd,
  input  logic [7:0]        pmem_data,
  output logic [OPC_W-1:0]  opcode,
  input  logic [CNT_W-1:0]  argc,
  input  logic [CNT_W-1:0]  stackargs,
  input  logic              stackwb,
  input  logic              isgoto,
  input  logic              iscmp,
  output logic [ARGS_W-1:0] args,
  output logic              stk_pop,
  output logic              stk_push,
  input  logic              stk_empty,
  input  logic              stk_full,
  output logic              exec_start,
  input  logic              exec_done,
  input  logic              cmp_true,
  output logic              halted,
  output logic              fault
);

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  opc_pc;
  logic [CNT_W-1:0] cnt;
  logic             branch_cmp;
  logic [PC_W-1:0]  target_c;
  logic             take_c;
  logic [PC_W-1:0]  next_pc_c;

  bytecode_sequencer_branch_target_calc #(
    .PC_W (PC_W)
  ) u_branch_target_calc (
    .opc_pc   (opc_pc),
    .offset   (args),
    .isgoto   (isgoto),
    .iscmp    (iscmp),
    .cmp_true (branch_cmp),
    .target_c (target_c),
    .take_c   (take_c)
  );

  assign next_pc_c = take_c ? target_c : pc;

  // Stack strobes are qualified by the same-cycle flags so a pop into an empty
  // stack or a push into a full one never reaches the stack.
  assign stk_pop  = (state == ST_POP) && !stk_empty;
  assign stk_push = (state == ST_WB) && stackwb && !stk_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      pc         <= '0;
      opc_pc     <= '0;
      cnt        <= '0;
      branch_cmp <= 1'b0;
      pmem_addr  <= '0;
      pmem_rd    <= 1'b0;
      opcode     <= '0;
      args       <= '0;
      exec_start <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      case (state)
        // pmem_rd low here only straight out of reset: issue the read first
        ST_FETCH: begin
          if (pmem_rd) begin
            pmem_rd <= 1'b0;
            opc_pc  <= pc;
            state   <= ST_OPC;
          end else begin
            pmem_rd   <= 1'b1;
            pmem_addr <= pc;
          end
        end
        ST_OPC: begin
          opcode <= pmem_data;
          pc     <= pc + PC_W'(1);
          args   <= '0;
          state  <= ST_DECODE;
        end
        ST_DECODE: begin
          if (is_return(opcode)) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else if (argc != ARGC_NONE) begin
            cnt       <= argc;
            pmem_rd   <= 1'b1;
            pmem_addr <= pc;
            state     <= ST_ARG;
          end else if (stackargs != STKARGS_NONE) begin
            cnt   <= stackargs;
            state <= ST_POP;
          end else begin
            exec_start <= 1'b1;
            state      <= ST_EXEC;
          end
        end
        // Read cycle while pmem_rd is up, capture cycle once it drops
        ST_ARG: begin
          if (pmem_rd) begin
            pmem_rd <= 1'b0;
          end else begin
            args <= {args[7:0], pmem_data};
            pc   <= pc + PC_W'(1);
            cnt  <= cnt - 2'd1;
            if (cnt != 2'd1) begin
              pmem_rd   <= 1'b1;
              pmem_addr <= pc + PC_W'(1);
            end else if (stackargs != STKARGS_NONE) begin
              cnt   <= stackargs;
              state <= ST_POP;
            end else begin
              exec_start <= 1'b1;
              state      <= ST_EXEC;
            end
          end
        end
        ST_POP: begin
          if (stk_empty) begin
            fault <= 1'b1;
            state <= ST_FAULT;
          end else begin
            cnt <= cnt - 2'd1;
            if (cnt == 2'd1) begin
              exec_start <= 1'b1;
              state      <= ST_EXEC;
            end
          end
        end
        // exec_done is only meaningful after the start pulse has gone
        ST_EXEC: begin
          exec_start <= 1'b0;
          if (!exec_start && exec_done) begin
            branch_cmp <= cmp_true;
            state      <= ST_WB;
          end
        end
        ST_WB: begin
          if (stackwb && stk_full) begin
            fault <= 1'b1;
            state <= ST_FAULT;
          end else begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          pc        <= next_pc_c;
          pmem_rd   <= 1'b1;
          pmem_addr <= next_pc_c;
          state     <= ST_FETCH;
        end
        ST_HALT:  state <= ST_HALT;
        ST_FAULT: state <= ST_FAULT;
        default: begin
          fault <= 1'b1;
          state <= ST_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bytecode_sequencer.sv
// Scoreboard bench: directed programs push expected bus events; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_bytecode_sequencer;

  localparam int unsigned PC_W = 16;
  localparam logic [2:0] K_READ  = 3'd0;
  localparam logic [2:0] K_EXEC  = 3'd1;
  localparam logic [2:0] K_PUSH  = 3'd2;
  localparam logic [2:0] K_HALT  = 3'd3;
  localparam logic [2:0] K_FAULT = 3'd4;
  localparam int STK_CAP = 4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] data;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [PC_W-1:0] pmem_addr;
  logic            pmem_rd;
  logic [7:0]      pmem_data = 8'h00;
  logic [7:0]      opcode;
  logic [1:0]      argc;
  logic [1:0]      stackargs;
  logic            stackwb;
  logic            isgoto;
  logic            iscmp;
  logic [15:0]     args;
  logic            stk_pop;
  logic            stk_push;
  logic            stk_empty;
  logic            stk_full;
  logic            exec_start;
  logic            exec_done = 1'b0;
  logic            cmp_true;
  logic            halted;
  logic            fault;

  bytecode_sequencer #(.PC_W(PC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pmem_addr  (pmem_addr),
    .pmem_rd    (pmem_rd),
    .pmem_data  (pmem_data),
    .opcode     (opcode),
    .argc       (argc),
    .stackargs  (stackargs),
    .stackwb    (stackwb),
    .isgoto     (isgoto),
    .iscmp      (iscmp),
    .args       (args),
    .stk_pop    (stk_pop),
    .stk_push   (stk_push),
    .stk_empty  (stk_empty),
    .stk_full   (stk_full),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .cmp_true   (cmp_true),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Program memory: one-cycle read latency
  logic [7:0] mem [0:65535];
  always @(posedge clk) if (pmem_rd) pmem_data <= mem[pmem_addr];

  // Opcode decoder model
  always_comb begin
    argc = 2'd0; stackargs = 2'd0; stackwb = 1'b0; isgoto = 1'b0; iscmp = 1'b0;
    case (opcode)
      8'h10: begin argc = 2'd1; stackwb = 1'b1; end
      8'hA7: begin argc = 2'd2; isgoto = 1'b1; end
      8'hA1: begin argc = 2'd2; stackargs = 2'd2; iscmp = 1'b1; end
      8'h60: begin stackargs = 2'd2; stackwb = 1'b1; end
      default: ;
    endcase
  end

  // Stack depth model
  int depth = 0;
  int depth_init = 0;
  always @(posedge clk) begin
    if (!rst_n) depth <= depth_init;
    else        depth <= depth - int'(stk_pop) + int'(stk_push);
  end
  assign stk_empty = (depth == 0);
  assign stk_full  = (depth >= STK_CAP);

  // Datapath responder: exec_done exec_lat cycles after the first legal cycle
  int exec_lat = 0;
  int pend = 0;
  always @(posedge clk) begin
    exec_done <= 1'b0;
    if (exec_start) begin
      if (exec_lat == 0) exec_done <= 1'b1;
      else               pend <= exec_lat;
    end else if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) exec_done <= 1'b1;
    end
  end

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  function automatic string kname(input logic [2:0] k);
    case (k)
      K_READ:  return "READ";
      K_EXEC:  return "EXEC";
      K_PUSH:  return "PUSH";
      K_HALT:  return "HALT";
      K_FAULT: return "FAULT";
      default: return "?";
    endcase
  endfunction

  task automatic observe(input logic [2:0] k, input logic [31:0] d);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got %s %h, expected no event", kname(k), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.data !== d) begin
        miscompares++;
        $display("FAIL event_seq: got %s %h, expected %s %h", kname(k), d, kname(e.kind), e.data);
      end
    end
  endtask

  // Monitor
  int   pops = 0;
  logic halted_q = 1'b0;
  logic fault_q = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pops     <= 0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      if (stk_pop && stk_push) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_push_overlap: got pop=1 push=1, expected not both");
      end
      if (pmem_rd) observe(K_READ, 32'(pmem_addr));
      if (exec_start) observe(K_EXEC, {opcode, args, 8'(pops)});
      if (stk_push) observe(K_PUSH, 32'd0);
      if (halted && !halted_q) observe(K_HALT, 32'(pops));
      if (fault && !fault_q) observe(K_FAULT, 32'(pops));
      pops     <= exec_start ? 0 : pops + int'(stk_pop);
      halted_q <= halted;
      fault_q  <= fault;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic put(input int a, input logic [7:0] b);
    mem[a] = b;
  endtask

  task automatic ex(input logic [2:0] k, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic ex_exec(input logic [7:0] op, input logic [15:0] a, input int p);
    ex(K_EXEC, {op, a, 8'(p)});
  endtask

  task automatic chk_reset_outputs();
    chk("reset_outputs",
        64'({pmem_addr, pmem_rd, opcode, args, stk_pop, stk_push, exec_start, halted, fault}),
        64'd0);
  endtask

  // Hold reset, verify quiescent outputs, clear memory, set environment
  task automatic start_prog(input int d0, input logic cmp, input int lat);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    depth_init = d0;
    cmp_true   = cmp;
    exec_lat   = lat;
    exp_q.delete();
    for (int i = 0; i < 65536; i++) mem[i] = 8'hAC;
  endtask

  task automatic release_rst();
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d events outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic finish_prog(input logic [1:0] sticky);
    drain();
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("sticky_halted_fault", 64'({halted, fault}), 64'(sticky));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cmp_true = 1'b0;

    // BIPUSH 5: one arg, no pops, one push, next fetch at 2
    start_prog(0, 1'b0, 0);
    put(0, 8'h10); put(1, 8'h05);
    ex(K_READ, 0); ex(K_READ, 1); ex_exec(8'h10, 16'h0005, 0); ex(K_PUSH, 0);
    ex(K_READ, 2); ex(K_HALT, 0);
    release_rst();
    finish_prog(2'b10);

    // GOTO forward chain 0 -> 4 -> 0x0E
    start_prog(0, 1'b0, 1);
    put(0, 8'hA7); put(1, 8'h00); put(2, 8'h04);
    put(4, 8'hA7); put(5, 8'h00); put(6, 8'h0A);
    ex(K_READ, 0); ex(K_READ, 1); ex(K_READ, 2); ex_exec(8'hA7, 16'h0004, 0);
    ex(K_READ, 4); ex(K_READ, 5); ex(K_READ, 6); ex_exec(8'hA7, 16'h000A, 0);
    ex(K_READ, 32'h0E); ex(K_HALT, 0);
    release_rst();
    finish_prog(2'b10);

    // GOTO backward: at 8, offset -4 -> 4
    start_prog(0, 1'b0, 0);
    put(0, 8'hA7); put(1, 8'h00); put(2, 8'h08);
    put(8, 8'hA7); put(9, 8'hFF); put(10, 8'hFC);
    ex(K_READ, 0); ex(K_READ, 1); ex(K_READ, 2); ex_exec(8'hA7, 16'h0008, 0);
    ex(K_READ, 8); ex(K_READ, 9); ex(K_READ, 10); ex_exec(8'hA7, 16'hFFFC, 0);
    ex(K_READ, 4); ex(K_HALT, 0);
    release_rst();
    finish_prog(2'b10);

    // IF_ICMPLT at 0x20, taken and not taken
    for (int t = 1; t >= 0; t--) begin
      start_prog(2, 1'(t), 2);
      put(0, 8'hA7); put(1, 8'h00); put(2, 8'h20);
      put(32'h20, 8'hA1); put(32'h21, 8'h00); put(32'h22, 8'h08);
      ex(K_READ, 0); ex(K_READ, 1); ex(K_READ, 2); ex_exec(8'hA7, 16'h0020, 0);
      ex(K_READ, 32'h20); ex(K_READ, 32'h21); ex(K_READ, 32'h22); ex_exec(8'hA1, 16'h0008, 2);
      ex(K_READ, (t != 0) ? 32'h28 : 32'h23); ex(K_HALT, 0);
      release_rst();
      finish_prog(2'b10);
    end

    // IADD on empty stack: underflow fault, no pop, no exec
    start_prog(0, 1'b0, 0);
    put(0, 8'h60);
    ex(K_READ, 0); ex(K_FAULT, 0);
    release_rst();
    finish_prog(2'b01);

    // BIPUSH into a full stack: overflow fault at writeback, no push
    start_prog(STK_CAP, 1'b0, 0);
    put(0, 8'h10); put(1, 8'h05);
    ex(K_READ, 0); ex(K_READ, 1); ex_exec(8'h10, 16'h0005, 0); ex(K_FAULT, 0);
    release_rst();
    finish_prog(2'b01);

    // PC wrap at 0xFFFF, arg fetched from 0x0000, unknown opcodes as NOP
    start_prog(0, 1'b0, 2);
    put(0, 8'hA7); put(1, 8'hFF); put(2, 8'hFE);
    put(32'hFFFE, 8'h00); put(32'hFFFF, 8'h10);
    ex(K_READ, 0); ex(K_READ, 1); ex(K_READ, 2); ex_exec(8'hA7, 16'hFFFE, 0);
    ex(K_READ, 32'hFFFE); ex_exec(8'h00, 16'h0000, 0);
    ex(K_READ, 32'hFFFF); ex(K_READ, 0); ex_exec(8'h10, 16'h00A7, 0); ex(K_PUSH, 0);
    ex(K_READ, 1); ex_exec(8'hFF, 16'h0000, 0);
    ex(K_READ, 2); ex_exec(8'hFE, 16'h0000, 0);
    ex(K_READ, 3); ex(K_HALT, 0);
    release_rst();
    finish_prog(2'b10);

    // Reset during EXEC: late exec_done is ignored and fetch restarts at 0
    start_prog(0, 1'b0, 6);
    put(0, 8'h10); put(1, 8'h05);
    ex(K_READ, 0); ex(K_READ, 1); ex_exec(8'h10, 16'h0005, 0);
    release_rst();
    drain();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exec_lat = 0;
    ex(K_READ, 0); ex(K_READ, 1); ex_exec(8'h10, 16'h0005, 0); ex(K_PUSH, 0);
    ex(K_READ, 2); ex(K_HALT, 0);
    @(negedge clk);
    chk_reset_outputs();
    finish_prog(2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bytecode_sequencer.md
Name: bytecode_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the bytecode core.
- Owns the PC and fetches opcode and argument bytes from program memory.
- Presents each opcode to the combinational decoder and uses its argc/stackargs/stackwb/isgoto/iscmp outputs to sequence stack pops, one execute handshake and the optional writeback push.
- Resolves GOTO and conditional branches; halts on return opcodes.

Parameters:
PC_W, 16, program counter / program memory address width
DATA_W, 32, stack operand width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low (single clock domain)
pmem_addr  out  PC_W  program memory byte address
pmem_rd  out  1  program memory read strobe; data returned exactly 1 cycle later
pmem_data  in  8  program memory read data
opcode  out  8  latched opcode, to decoder
argc  in  2  decoder: argument byte count
stackargs  in  2  decoder: operands to pop
stackwb  in  1  decoder: push result
isgoto  in  1  decoder: unconditional branch
iscmp  in  1  decoder: conditional branch
args  out  16  latched argument bytes {arg0,arg1}; arg0 in [15:8] when argc=2, else in [7:0]
stk_pop  out  1  pop one stack word this cycle
stk_push  out  1  push exec_result this cycle
stk_empty  in  1  stack empty flag
stk_full  in  1  stack full flag
exec_start  out  1  one-cycle pulse to datapath (ALU/LVA/array/const)
exec_done  in  1  datapath result valid; may coincide with exec_start's following cycle or later
cmp_true  in  1  branch condition result, sampled with exec_done
halted  out  1  return opcode executed
fault  out  1  stack underflow/overflow detected

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state including mid-instruction:
  - PC=0, state=FETCH.
  - All outputs 0: opcode=0x00, args=0, strobes low, halted=0, fault=0.
- States and transitions:
  - FETCH: pmem_rd=1, pmem_addr=PC, opc_pc<=PC. Go to OPC.
  - OPC: latch pmem_data into opcode; PC<=PC+1; clear args. Go to DECODE.
  - DECODE: one cycle for decoder outputs to settle.
    - If opcode is 0xAC, 0xB0 or 0xB1: go to HALT.
    - Else latch argc into cnt and go to ARG if argc>0, else POP.
  - ARG: issue read at PC, then capture the byte next cycle; args<={args[7:0],byte}; PC+=1; cnt-=1. Loop until cnt=0, then POP.
  - POP: one stk_pop per cycle, stackargs times.
    - If stk_empty is high in a cycle where a pop is required: go to FAULT and pop nothing.
    - stackargs=0 skips directly to EXEC.
  - EXEC: exec_start pulse in the first cycle, then wait for exec_done. Unbounded wait, no timeout.
  - WB: if stackwb, stk_push=1 for one cycle. stk_full high at this point -> FAULT, no push.
  - NEXT: update PC, then go to FETCH.
    - Branch target = opc_pc + sign-extended 16-bit args, computed modulo 2^PC_W.
    - isgoto: PC<=target.
    - iscmp and cmp_true: PC<=target.
    - Otherwise PC is left as advanced past the argument bytes.
  - HALT: halted=1, sticky until reset. No further memory or stack activity.
  - FAULT: fault=1, sticky until reset. Same quiescence as HALT.
- Per-instruction latency: 3 (fetch/decode) + 2·argc + stackargs + exec wait (≥2) + 1 WB + 1 NEXT cycles.
- Strobe rules:
  - stk_pop and stk_push are never high in the same cycle.
  - exec_start is high in exactly one cycle per instruction, including NOP.
- PC wrap: at 2^PC_W-1, PC+1 wraps to 0 with no error.
- Opcodes the decoder does not recognise execute as NOP; their argc is taken as reported.

Decomposition:
- Shared package: state enum; return opcode constants (IRETURN, ARETURN, RETURN); argc/stackargs encodings. Opcode constants are reused from the existing opcode header.
- One natural sub-module: branch_target_calc. Combinational: opc_pc + sign-extended offset, plus the take/not-take decision.

Test Plan:
- BIPUSH: mem[0..1]=0x10,0x05 with stack empty -> args=0x0005; no pops; exactly 1 exec_start; 1 push; next fetch at PC=2.
- GOTO forward: mem[4..6]=0xA7,0x00,0x0A -> next fetch at 0x000E. GOTO backward: 0xA7,0xFF,0xFC at addr 8 -> next fetch at 0x0004.
- IF_ICMPLT: at addr 0x20, 0xA1,0x00,0x08, stack depth 2 -> 2 pops. cmp_true=1: PC=0x28. Rerun with cmp_true=0: PC=0x23.
- IADD (0x60) with stk_empty=1 -> fault=1 in the pop cycle; no stk_pop or exec_start afterwards; stays faulted until reset.
- IRETURN (0xAC) at addr 3 -> halted=1 after DECODE; pmem_rd stays 0 thereafter.
- rst_n=0 for one edge while in EXEC -> next cycle all outputs 0 and PC=0; exec_done arriving late is ignored; fetch restarts at addr 0.
